// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serialising single-port RAM controller arbitrating IF and MEM
// MEM has fixed priority; each access becomes N byte cycles, reads assembled little-endian.
module mem_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [31:0]       if_data_o,
   output logic              if_done_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [1:0]        mem_sel_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   output logic [31:0]       mem_rdata_o,
   output logic              mem_done_o,
   input  logic [7:0]        ram_din_i,
   output logic [7:0]        ram_dout_o,
   output logic [ADDR_W-1:0] ram_a_o,
   output logic              ram_wr_o
);

   typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

   state_t            state;
   logic [2:0]        cnt;
   logic [2:0]        n;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rbuf;
   logic [31:0]       rbuf_next;
   logic [1:0]        lane;

   // RAM data lags its address by two edges, so lane = cnt - 2 while reading.
   always_comb begin
      lane      = cnt[1:0] - 2'd2;
      rbuf_next = rbuf;
      if (cnt >= 3'd2)
         rbuf_next[{lane, 3'b000} +: 8] = ram_din_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         n           <= '0;
         addr        <= '0;
         wdata       <= '0;
         rbuf        <= '0;
         if_data_o   <= '0;
         if_done_o   <= 1'b0;
         mem_rdata_o <= '0;
         mem_done_o  <= 1'b0;
         ram_dout_o  <= '0;
         ram_a_o     <= '0;
         ram_wr_o    <= 1'b0;
      end else begin
         if_done_o  <= 1'b0;
         mem_done_o <= 1'b0;
         case (state)
            IDLE: begin
               // A done pulse on this edge forces one idle cycle before the next accept.
               if (!if_done_o && !mem_done_o) begin
                  if (mem_req_i) begin
                     addr    <= mem_addr_i;
                     wdata   <= mem_wdata_i;
                     rbuf    <= '0;
                     cnt     <= 3'd1;
                     ram_a_o <= mem_addr_i;
                     case (mem_sel_i)
                        2'b00:   n <= 3'd1;
                        2'b01:   n <= 3'd2;
                        default: n <= 3'd4;
                     endcase
                     if (mem_we_i) begin
                        ram_wr_o   <= 1'b1;
                        ram_dout_o <= mem_wdata_i[7:0];
                        state      <= MEM_WR;
                     end else begin
                        state <= MEM_RD;
                     end
                  end else if (if_req_i) begin
                     addr    <= if_addr_i;
                     rbuf    <= '0;
                     cnt     <= 3'd1;
                     n       <= 3'd4;
                     ram_a_o <= if_addr_i;
                     state   <= IF_RD;
                  end
               end
            end
            IF_RD, MEM_RD: begin
               rbuf    <= rbuf_next;
               cnt     <= cnt + 3'd1;
               ram_a_o <= (cnt < n) ? addr + ADDR_W'(cnt) : '0;
               if (cnt == n + 3'd1) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (state == IF_RD) begin
                     if_data_o <= rbuf_next;
                     if_done_o <= 1'b1;
                  end else begin
                     mem_rdata_o <= rbuf_next;
                     mem_done_o  <= 1'b1;
                  end
               end
            end
            MEM_WR: begin
               if (cnt < n) begin
                  ram_a_o    <= addr + ADDR_W'(cnt);
                  ram_dout_o <= wdata[{cnt[1:0], 3'b000} +: 8];
                  cnt        <= cnt + 3'd1;
               end else begin
                  ram_wr_o   <= 1'b0;
                  ram_a_o    <= '0;
                  ram_dout_o <= '0;
                  mem_done_o <= 1'b1;
                  cnt        <= '0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
